// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
// The master side is the arbiter; the slave side is the agent cluster.
interface rr_decode_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    modport master (
        input  req,
        output grant,
        output sel,
        output busy,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  sel,
        input  busy,
        input  preempt
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 decoder among four requesters.
// Grants are held for a bounded tenure and always followed by an idle bubble.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_decode_arbiter_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    // Scan from ptr upward so the last winner has lowest priority.
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                if (found) begin
                    state_d = BUSY;
                    sel_d   = win;
                    grant_d = 4'(1) << win;
                    busy_d  = 1'b1;
                    hcnt_d  = 8'd0;
                    ptr_d   = win + 2'd1;
                end
            end
            BUSY: begin
                if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end else if (hcnt_q == 8'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    preempt_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            hcnt_q    <= 8'd0;
            sel_q     <= 2'd0;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q));
    a_busy: assert property (@(posedge clk) disable iff (rst)
        ((grant_q != 4'b0000) == busy_q));
    a_dec: assert property (@(posedge clk) disable iff (rst)
        (busy_q |-> (grant_q == (4'(1) << sel_q))));

endmodule
